dmem_controller: RTL and testbench
==================================

Name: dmem_controller

Overview:
MEM-stage data-memory responder. Consumes load/store requests held in the EX/MEM pipeline register and runs them on a word-wide, variable-latency req/ack memory bus. Freezes the pipeline through StallController until each transaction completes, then returns a lane-aligned, sign- or zero-extended MemReadData to the MEM/WB register. Also owns the LL/SC link state and misalignment detection.

Parameters:
ADDR_W, 30, word-address width of bus_addr (byte address bits [ADDR_W+1:2]).
BIG_ENDIAN, 1, 1: byte 0 is bits 31:24; 0: byte 0 is bits 7:0.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
Stall  in  1  global pipeline stall from other sources; holds DONE
Flush  in  1  CP0 flush; cancels current MEM instruction
MemRead, MemWrite  in  1  load / store request (from EX/MEM)
MemHalf, MemByte  in  1  size select; neither set = word
MemSignExtend  in  1  sign-extend sub-word loads
LLSC  in  1  with MemRead = LL, with MemWrite = SC
ALUResult  in  32  byte address
ReadData2  in  32  store data (right-justified)
MemReadData  out  32  load result / SC status
StallController  out  1  pipeline freeze request
AddrError  out  1  misaligned access, combinational
bus_req  out  1  bus request, held until ack
bus_we  out  1  write strobe
bus_addr  out  ADDR_W  word address
bus_be  out  4  byte enables
bus_wdata  out  32  lane-replicated write data
bus_rdata  in  32  read data, valid with bus_ack
bus_ack  in  1  one-cycle completion pulse

Behaviour:
- Reset: state IDLE; MemReadData, bus_req, bus_we, bus_be, bus_addr, bus_wdata, StallController, AddrError = 0; link bit = 0, link address = 0.
- States:
  - IDLE: a valid request is MemRead|MemWrite, aligned, not Flush, and not a failing SC.
  - IDLE to BUSY on a valid request. StallController rises combinationally in the same cycle.
  - BUSY: bus outputs are registered at entry and held stable while bus_req=1. bus_ack is sampled only in BUSY; the earliest ack is the first BUSY cycle.
  - BUSY to DONE on bus_ack. Read data is formatted and captured into MemReadData.
  - DONE: StallController=0 and MemReadData is held. Stay in DONE while Stall=1; otherwise go to IDLE. DONE never reissues.
- Latency: request at cycle 0, ack at cycle k≥1, data valid and stall low at k+1.
- Alignment and AddrError:
  - Half requires addr[0]=0. Word requires addr[1:0]=00.
  - On a violation: AddrError=1, no bus transaction, no stall, state remains IDLE.
- Load formatting:
  - Word: rdata passed through.
  - Half: lane selected by addr[1]. Byte: lane selected by addr[1:0], per BIG_ENDIAN.
  - Sub-word result is sign- or zero-extended per MemSignExtend.
- Store formatting:
  - Byte: bus_wdata = {4{wd[7:0]}}, one-hot bus_be.
  - Half: bus_wdata = {2{wd[15:0]}}, bus_be = 1100 or 0011.
  - Word: bus_be = 1111.
- LL: behaves as a word load. At ack, set the link bit and store link address = addr[31:2].
- SC:
  - Succeeds if the link bit is set and the link address equals addr[31:2]. Performs the word store; MemReadData=1 in DONE.
  - Fails otherwise: no bus transaction, no stall, MemReadData=0 registered the next cycle.
  - Either outcome clears the link bit.
- Flush:
  - In IDLE: suppresses the request.
  - In BUSY: the bus transaction still runs to ack and cannot be aborted. A drop flag is set, so at ack the block goes to IDLE, not DONE, and MemReadData is unchanged.
  - Any Flush clears the link bit.
- Async reset mid-BUSY: immediate IDLE and bus_req=0. The bus slave must tolerate an abandoned request.

Decomposition:
- Shared package (mem_pkg): state enum {IDLE, BUSY, DONE}, size encoding, lane-select and byte-enable constants.
- One natural sub-module, dmem_lane_align: combinational store replication/byte-enable generation and load extraction/extension, parameterised by BIG_ENDIAN.
- The FSM and link register live in the top level.

Test Plan:
- LW at 0x100, ack after 3 BUSY cycles, rdata=0xDEADBEEF → StallController high for 4 cycles, then MemReadData=0xDEADBEEF with stall low.
- LB sign-extend at addr 0x...3, rdata=0x11223380, BIG_ENDIAN=1 → MemReadData=0xFFFFFF80. LBU → 0x00000080.
- SH at 0x202, wd=0x0000ABCD → bus_be=0011, bus_wdata=0xABCDABCD, bus_addr=0x80.
- LL at 0x40 then SC at 0x40 → write issued, MemReadData=1. A second SC → no bus_req, MemReadData=0.
- LW at 0x101 → AddrError=1, bus_req never rises, StallController=0.
- Flush in the 2nd BUSY cycle of an LW with ack at the 4th → returns to IDLE at ack, MemReadData unchanged, link cleared.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM-stage data-memory controller.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } memState_t;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } memSize_t;

  // bus_be bit i enables bus data bits [8i+7:8i]
  localparam logic [3:0] BE_WORD    = 4'b1111;
  localparam logic [3:0] BE_HALF_LO = 4'b0011;
  localparam logic [3:0] BE_HALF_HI = 4'b1100;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;

  // Physical byte lane (0 = bits 7:0) holding the byte at address offset off
  function automatic logic [1:0] byteLane(input logic [1:0] off, input bit bigEndian);
    return bigEndian ? ~off : off;
  endfunction

  // Physical half lane (1 = bits 31:16) holding the half at address bit off1
  function automatic logic halfLane(input logic off1, input bit bigEndian);
    return bigEndian ? ~off1 : off1;
  endfunction

endpackage

// File: rtl/dmem_controller_if.sv
// Word-wide req/ack data-memory bus between the MEM stage and the memory slave.
interface dmem_controller_if #(
  parameter int ADDR_W = 30
) ();

  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [3:0]        bus_be;
  logic [31:0]       bus_wdata;
  logic [31:0]       bus_rdata;
  logic              bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store replication/byte enables and load
// extraction with sign or zero extension.
module dmem_lane_align
  import mem_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  memSize_t    size,
  input  logic [1:0]  offset,
  input  logic        signExtend,
  input  logic [31:0] storeData,
  input  logic [31:0] readData,
  output logic [3:0]  byteEnable,
  output logic [31:0] storeWord,
  output logic [31:0] loadWord
);

  logic [1:0]  bLane;
  logic        hLane;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  // Select lanes and format both directions for the current access size
  always_comb begin
    bLane      = byteLane(offset, BIG_ENDIAN);
    hLane      = halfLane(offset[1], BIG_ENDIAN);
    loadByte   = readData[{bLane, 3'b000} +: 8];
    loadHalf   = hLane ? readData[31:16] : readData[15:0];
    byteEnable = BE_WORD;
    storeWord  = storeData;
    loadWord   = readData;
    case (size)
      SZ_BYTE: begin
        byteEnable = BE_BYTE0 << bLane;
        storeWord  = {4{storeData[7:0]}};
        loadWord   = {{24{signExtend & loadByte[7]}}, loadByte};
      end
      SZ_HALF: begin
        byteEnable = hLane ? BE_HALF_HI : BE_HALF_LO;
        storeWord  = {2{storeData[15:0]}};
        loadWord   = {{16{signExtend & loadHalf[15]}}, loadHalf};
      end
      default: begin
        byteEnable = BE_WORD;
        storeWord  = storeData;
        loadWord   = readData;
      end
    endcase
  end

endmodule

// File: rtl/dmem_controller.sv
// MEM-stage data-memory controller: runs loads/stores on a variable-latency
// req/ack bus, freezes the pipeline while busy, and owns the LL/SC link.
module dmem_controller
  import mem_pkg::*;
#(
  parameter int ADDR_W     = 30,
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemHalf,
  input  logic        MemByte,
  input  logic        MemSignExtend,
  input  logic        LLSC,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  output logic [31:0] MemReadData,
  output logic        StallController,
  output logic        AddrError,
  dmem_controller_if.master bus
);

  memState_t   state, nextState;
  memSize_t    liveSize, reqSize, alignSize;
  logic [1:0]  reqOffset, alignOffset;
  logic        reqSign, alignSign;
  logic        reqWrite, reqLL, reqSC, dropFlag;
  logic [29:0] reqLinkAddr, linkAddr;
  logic        linkBit;
  logic        anyReq, misaligned, scAttempt, linkMatch;
  logic        startReq, scFailNow;
  logic [3:0]  alignBe;
  logic [31:0] alignStore, alignLoad;

  // Decode the live EX/MEM request: size, alignment, SC outcome and start
  always_comb begin
    liveSize   = LLSC ? SZ_WORD : (MemByte ? SZ_BYTE : (MemHalf ? SZ_HALF : SZ_WORD));
    anyReq     = MemRead | MemWrite;
    misaligned = 1'b0;
    case (liveSize)
      SZ_HALF: misaligned = ALUResult[0];
      SZ_WORD: misaligned = |ALUResult[1:0];
      default: misaligned = 1'b0;
    endcase
    scAttempt       = MemWrite & LLSC;
    linkMatch       = linkBit & (linkAddr == ALUResult[31:2]);
    startReq        = (state == IDLE) & anyReq & ~misaligned & ~Flush & ~(scAttempt & ~linkMatch);
    scFailNow       = (state == IDLE) & scAttempt & ~misaligned & ~Flush & ~linkMatch;
    AddrError       = (state == IDLE) & anyReq & misaligned & ~Flush;
    StallController = startReq | (state == BUSY);
  end

  // Lane formatter sees live attributes when issuing, captured ones at ack
  always_comb begin
    alignSize   = (state == IDLE) ? liveSize : reqSize;
    alignOffset = (state == IDLE) ? ALUResult[1:0] : reqOffset;
    alignSign   = (state == IDLE) ? MemSignExtend : reqSign;
  end

  dmem_lane_align #(
    .BIG_ENDIAN(BIG_ENDIAN)
  ) uLaneAlign (
    .size      (alignSize),
    .offset    (alignOffset),
    .signExtend(alignSign),
    .storeData (ReadData2),
    .readData  (bus.bus_rdata),
    .byteEnable(alignBe),
    .storeWord (alignStore),
    .loadWord  (alignLoad)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Next-state logic; a flushed transaction still waits for its ack
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (startReq) nextState = BUSY;
      BUSY: if (bus.bus_ack) nextState = (dropFlag | Flush) ? IDLE : DONE;
      DONE: if (!Stall) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Bus outputs, captured request attributes and the load/SC result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.bus_req   <= 1'b0;
      bus.bus_we    <= 1'b0;
      bus.bus_addr  <= '0;
      bus.bus_be    <= '0;
      bus.bus_wdata <= '0;
      MemReadData   <= '0;
      reqSize       <= SZ_WORD;
      reqOffset     <= '0;
      reqSign       <= 1'b0;
      reqWrite      <= 1'b0;
      reqLL         <= 1'b0;
      reqSC         <= 1'b0;
      reqLinkAddr   <= '0;
      dropFlag      <= 1'b0;
    end else begin
      if (startReq) begin
        bus.bus_req   <= 1'b1;
        bus.bus_we    <= MemWrite;
        bus.bus_addr  <= ALUResult[ADDR_W+1:2];
        bus.bus_be    <= alignBe;
        bus.bus_wdata <= MemWrite ? alignStore : '0;
        reqSize       <= liveSize;
        reqOffset     <= ALUResult[1:0];
        reqSign       <= MemSignExtend;
        reqWrite      <= MemWrite;
        reqLL         <= MemRead & ~MemWrite & LLSC;
        reqSC         <= scAttempt;
        reqLinkAddr   <= ALUResult[31:2];
        dropFlag      <= 1'b0;
      end else if (state == BUSY) begin
        if (Flush) dropFlag <= 1'b1;
        if (bus.bus_ack) begin
          bus.bus_req <= 1'b0;
          bus.bus_we  <= 1'b0;
          if (!dropFlag && !Flush) begin
            if (reqSC)          MemReadData <= 32'd1;
            else if (!reqWrite) MemReadData <= alignLoad;
          end
        end
      end
      if (scFailNow) MemReadData <= '0;
    end
  end

  // LL/SC link: set by a completed LL, cleared by any SC or any flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      linkBit  <= 1'b0;
      linkAddr <= '0;
    end else if (Flush || scFailNow || (startReq && scAttempt)) begin
      linkBit <= 1'b0;
    end else if ((state == BUSY) && bus.bus_ack && !dropFlag && reqLL) begin
      linkBit  <= 1'b1;
      linkAddr <= reqLinkAddr;
    end
  end

endmodule

// File: tb/tb_dmem_controller.sv
// Bench for dmem_controller: variable-latency bus slave plus an
// expected-result queue popped when each transaction reaches DONE.
module tb_dmem_controller;

  localparam int ADDR_W = 30;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Stall, Flush, MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, LLSC;
  logic [31:0] ALUResult, ReadData2, MemReadData;
  logic        StallController, AddrError;

  always #5 clk = ~clk;

  dmem_controller_if #(.ADDR_W(ADDR_W)) busIf ();

  dmem_controller #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Stall          (Stall),
    .Flush          (Flush),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .MemHalf        (MemHalf),
    .MemByte        (MemByte),
    .MemSignExtend  (MemSignExtend),
    .LLSC           (LLSC),
    .ALUResult      (ALUResult),
    .ReadData2      (ReadData2),
    .MemReadData    (MemReadData),
    .StallController(StallController),
    .AddrError      (AddrError),
    .bus            (busIf)
  );

  // Bus slave: ack is asserted in the ackDelay-th cycle of an outstanding request
  int          ackDelay = 1;
  int          busyCnt = 0;
  logic [31:0] slaveData = '0;
  assign busIf.bus_ack   = busIf.bus_req && (busyCnt == ackDelay - 1);
  assign busIf.bus_rdata = slaveData;

  always @(posedge clk) begin
    if (busIf.bus_req && !busIf.bus_ack) busyCnt <= busyCnt + 1;
    else                                 busyCnt <= 0;
  end

  int          reqCount = 0;
  logic        prevReq = 1'b0;
  logic [31:0] capAddr = '0, capWdata = '0;
  logic [3:0]  capBe = '0;
  logic        capWe = 1'b0;

  always @(posedge clk) begin
    prevReq <= busIf.bus_req;
    if (busIf.bus_req && !prevReq) reqCount <= reqCount + 1;
    if (busIf.bus_req && busIf.bus_ack) begin
      capAddr  <= 32'(busIf.bus_addr);
      capWdata <= busIf.bus_wdata;
      capBe    <= busIf.bus_be;
      capWe    <= busIf.bus_we;
    end
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] expQ[$];
  logic [31:0] modelMrd = '0;
  int          stallCycles;
  int          reqBefore;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic clearReq();
    MemRead = 0; MemWrite = 0; MemHalf = 0; MemByte = 0;
    MemSignExtend = 0; LLSC = 0; ALUResult = '0; ReadData2 = '0;
  endtask

  // Drive one request at a negedge, count stall cycles, then compare the result
  task automatic runOp(input string tag, input logic rd, input logic wr, input logic half,
                       input logic byt, input logic sx, input logic llsc,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int delay, input logic [31:0] rdata, input bit hold,
                       output int nStall);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; MemHalf = half; MemByte = byt;
    MemSignExtend = sx; LLSC = llsc; ALUResult = addr; ReadData2 = wd;
    ackDelay = delay; slaveData = rdata;
    #1;
    nStall = 0;
    while (StallController && nStall < 40) begin
      nStall++;
      @(negedge clk);
      #1;
    end
    if (nStall >= 40) checkVal({tag, "_timeout"}, 32'(StallController), 32'd0);
    if (expQ.size() > 0) checkVal({tag, "_data"}, MemReadData, expQ.pop_front());
    if (!hold) clearReq();
  endtask

  initial begin
    Stall = 0; Flush = 0;
    clearReq();
    repeat (3) @(negedge clk);
    checkVal("rst_mrd", MemReadData, 32'd0);
    checkVal("rst_stall", 32'(StallController), 32'd0);
    checkVal("rst_req", 32'(busIf.bus_req), 32'd0);
    checkVal("rst_be", 32'(busIf.bus_be), 32'd0);
    checkVal("rst_adderr", 32'(AddrError), 32'd0);
    rst_n = 1'b1;

    // Word load, ack in the third busy cycle
    modelMrd = 32'hDEADBEEF; expQ.push_back(modelMrd);
    runOp("lw", 1, 0, 0, 0, 0, 0, 32'h100, '0, 3, 32'hDEADBEEF, 0, stallCycles);
    checkVal("lw_stall", 32'(stallCycles), 32'd4);
    checkVal("lw_addr", capAddr, 32'h40);
    checkVal("lw_we", 32'(capWe), 32'd0);

    // Sub-word loads, big-endian lanes
    modelMrd = 32'hFFFFFF80; expQ.push_back(modelMrd);
    runOp("lb", 1, 0, 0, 1, 1, 0, 32'h103, '0, 2, 32'h11223380, 0, stallCycles);
    modelMrd = 32'h00000080; expQ.push_back(modelMrd);
    runOp("lbu", 1, 0, 0, 1, 0, 0, 32'h103, '0, 1, 32'h11223380, 0, stallCycles);
    modelMrd = 32'hFFFFF344; expQ.push_back(modelMrd);
    runOp("lh", 1, 0, 1, 0, 1, 0, 32'h102, '0, 2, 32'h1122F344, 0, stallCycles);
    modelMrd = 32'h00001122; expQ.push_back(modelMrd);
    runOp("lhu", 1, 0, 1, 0, 0, 0, 32'h100, '0, 1, 32'h1122F344, 0, stallCycles);

    // Stores: earliest ack, result register untouched
    expQ.push_back(modelMrd);
    runOp("sh", 0, 1, 1, 0, 0, 0, 32'h202, 32'h0000ABCD, 1, '0, 0, stallCycles);
    checkVal("sh_stall", 32'(stallCycles), 32'd2);
    checkVal("sh_be", 32'(capBe), 32'h3);
    checkVal("sh_wdata", capWdata, 32'hABCDABCD);
    checkVal("sh_addr", capAddr, 32'h80);
    checkVal("sh_we", 32'(capWe), 32'd1);
    expQ.push_back(modelMrd);
    runOp("sb", 0, 1, 0, 1, 0, 0, 32'h201, 32'h0000005A, 2, '0, 0, stallCycles);
    checkVal("sb_be", 32'(capBe), 32'h4);
    checkVal("sb_wdata", capWdata, 32'h5A5A5A5A);

    // LL then matching SC succeeds
    modelMrd = 32'h12345678; expQ.push_back(modelMrd);
    runOp("ll", 1, 0, 0, 0, 0, 1, 32'h40, '0, 2, 32'h12345678, 0, stallCycles);
    modelMrd = 32'd1; expQ.push_back(modelMrd);
    reqBefore = reqCount;
    runOp("sc_ok", 0, 1, 0, 0, 0, 1, 32'h40, 32'hCAFEF00D, 2, '0, 0, stallCycles);
    checkVal("sc_ok_reqs", 32'(reqCount - reqBefore), 32'd1);
    checkVal("sc_ok_wdata", capWdata, 32'hCAFEF00D);
    checkVal("sc_ok_be", 32'(capBe), 32'hF);
    checkVal("sc_ok_addr", capAddr, 32'h10);

    // Second SC fails: no stall, no bus request, zero the next cycle
    reqBefore = reqCount;
    @(negedge clk);
    MemWrite = 1; LLSC = 1; ALUResult = 32'h40; ReadData2 = 32'h1;
    #1;
    checkVal("sc_fail_stall", 32'(StallController), 32'd0);
    @(negedge clk);
    #1;
    modelMrd = 32'd0;
    checkVal("sc_fail_data", MemReadData, modelMrd);
    clearReq();
    @(negedge clk);
    checkVal("sc_fail_reqs", 32'(reqCount - reqBefore), 32'd0);

    // Misaligned word load
    reqBefore = reqCount;
    @(negedge clk);
    MemRead = 1; ALUResult = 32'h101;
    #1;
    checkVal("mis_adderr", 32'(AddrError), 32'd1);
    checkVal("mis_stall", 32'(StallController), 32'd0);
    repeat (3) @(negedge clk);
    checkVal("mis_reqs", 32'(reqCount - reqBefore), 32'd0);
    checkVal("mis_data", MemReadData, modelMrd);
    clearReq();

    // Stall holds DONE with no reissue
    Stall = 1;
    modelMrd = 32'h0F0F0F0F; expQ.push_back(modelMrd);
    reqBefore = reqCount;
    runOp("stl", 1, 0, 0, 0, 0, 0, 32'h104, '0, 2, 32'h0F0F0F0F, 1, stallCycles);
    repeat (3) @(negedge clk);
    #1;
    checkVal("stl_hold_data", MemReadData, modelMrd);
    checkVal("stl_hold_stall", 32'(StallController), 32'd0);
    checkVal("stl_reqs", 32'(reqCount - reqBefore), 32'd1);
    Stall = 0;
    clearReq();

    // Flush in the second busy cycle of a load acked in the fourth
    modelMrd = 32'h0BADF00D; expQ.push_back(modelMrd);
    runOp("ll2", 1, 0, 0, 0, 0, 1, 32'h80, '0, 1, 32'h0BADF00D, 0, stallCycles);
    @(negedge clk);
    MemRead = 1; ALUResult = 32'h300; ackDelay = 4; slaveData = 32'h99999999;
    @(negedge clk);
    @(negedge clk);
    Flush = 1; MemRead = 0;
    @(negedge clk);
    Flush = 0;
    #1;
    checkVal("fl_noabort", 32'(busIf.bus_req), 32'd1);
    @(negedge clk);
    @(negedge clk);
    #1;
    checkVal("fl_stall", 32'(StallController), 32'd0);
    checkVal("fl_req", 32'(busIf.bus_req), 32'd0);
    checkVal("fl_data", MemReadData, modelMrd);
    reqBefore = reqCount;
    MemWrite = 1; LLSC = 1; ALUResult = 32'h80;
    #1;
    checkVal("fl_link_stall", 32'(StallController), 32'd0);
    @(negedge clk);
    modelMrd = 32'd0;
    checkVal("fl_link_data", MemReadData, modelMrd);
    checkVal("fl_link_reqs", 32'(reqCount - reqBefore), 32'd0);
    clearReq();

    // Asynchronous reset while busy drops the request at once
    @(negedge clk);
    MemRead = 1; ALUResult = 32'h10; ackDelay = 10; slaveData = 32'h55555555;
    @(negedge clk);
    @(negedge clk);
    MemRead = 0;
    #1;
    checkVal("arst_pre_req", 32'(busIf.bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    checkVal("arst_req", 32'(busIf.bus_req), 32'd0);
    checkVal("arst_stall", 32'(StallController), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
